// File: rtl/ps2_cmd_ctrl.sv
// Command sequencer for one ps2_host channel: sends 1-2 byte commands, waits for the
// device 0xFA, retries on 0xFE/error/timeout, and buffers all other received bytes in a FIFO.
module ps2_cmd_ctrl #(
    parameter int unsigned CLK_FREQ       = 100,
    parameter int unsigned ACK_TIMEOUT_US = 20000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned FIFO_AW        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_arg_en,
    input  logic [7:0] cmd_arg,
    output logic       cmd_done,
    output logic       cmd_fail,
    input  logic       rx_enable,
    input  logic       fifo_rd,
    output logic [7:0] fifo_dout,
    output logic       fifo_empty,
    output logic       fifo_ovf,
    input  logic       ovf_clr,
    output logic [7:0] rx_err_cnt,
    output logic       h_tx_en,
    output logic [7:0] h_tx_data,
    output logic       h_rx_en,
    input  logic       h_tx_busy,
    input  logic       h_tx_ack,
    input  logic       h_tx_err,
    input  logic       h_rx_ack,
    input  logic       h_rx_err,
    input  logic [7:0] h_rx_data
);
    localparam int unsigned TO_CYC = CLK_FREQ * ACK_TIMEOUT_US;
    localparam int unsigned TW     = $clog2(TO_CYC + 1);
    localparam int unsigned RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned DEPTH  = 1 << FIFO_AW;

    localparam logic [7:0] ACK_BYTE    = 8'hFA;
    localparam logic [7:0] RESEND_BYTE = 8'hFE;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SEND     = 3'd1;
    localparam logic [2:0] S_WAIT_TX  = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_RETRY    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [7:0]    cmd_q, arg_q;
    logic          arg_en_q;
    logic          idx_q, idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          done_d, fail_d;
    logic          push;
    logic          timeout;

    assign timeout   = (timer_q == TW'(TO_CYC - 1));
    assign cmd_ready = (state_q == S_IDLE);
    assign h_tx_en   = (state_q == S_SEND);
    assign h_tx_data = idx_q ? arg_q : cmd_q;
    assign h_rx_en   = rx_enable;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        done_d  = 1'b0;
        fail_d  = 1'b0;
        // ACK/RESEND replies are consumed only while a reply is awaited
        push    = h_rx_ack;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_SEND;
                    idx_d   = 1'b0;
                    retry_d = '0;
                end
            end
            S_SEND: begin
                if (h_tx_busy) state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (h_tx_ack)      state_d = S_WAIT_ACK;
                else if (h_tx_err) state_d = S_RETRY;
            end
            S_WAIT_ACK: begin
                if (h_rx_ack && h_rx_data == ACK_BYTE) begin
                    push = 1'b0;
                    if (idx_q == arg_en_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = 1'b1;
                        retry_d = '0;
                        state_d = S_SEND;
                    end
                end else if (h_rx_ack && h_rx_data == RESEND_BYTE) begin
                    push    = 1'b0;
                    state_d = S_RETRY;
                end else if (h_rx_err || timeout) begin
                    state_d = S_RETRY;
                end
            end
            S_RETRY: begin
                if (retry_q == RW'(MAX_RETRY)) begin
                    state_d = S_IDLE;
                    fail_d  = 1'b1;
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
        timer_d = (state_q == S_WAIT_ACK && state_d == S_WAIT_ACK) ? timer_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cmd_q    <= 8'h00;
            arg_q    <= 8'h00;
            arg_en_q <= 1'b0;
            idx_q    <= 1'b0;
            retry_q  <= '0;
            timer_q  <= '0;
            cmd_done <= 1'b0;
            cmd_fail <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            timer_q  <= timer_d;
            cmd_done <= done_d;
            cmd_fail <= fail_d;
            if (state_q == S_IDLE && cmd_valid) begin
                cmd_q    <= cmd_byte;
                arg_q    <= cmd_arg;
                arg_en_q <= cmd_arg_en;
            end
        end
    end

    // RX FIFO, first-word-fall-through
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, pop, wr;

    assign full       = (count == (FIFO_AW + 1)'(DEPTH));
    assign fifo_empty = (count == '0);
    assign pop        = fifo_rd && !fifo_empty;
    assign wr         = push && (!full || pop);
    assign fifo_dout  = fifo_empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= h_rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_ovf   <= 1'b0;
            rx_err_cnt <= 8'h00;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop) fifo_ovf <= 1'b1;
            else if (ovf_clr)         fifo_ovf <= 1'b0;
            if (h_rx_err && rx_err_cnt != 8'hFF) rx_err_cnt <= rx_err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Bench for ps2_cmd_ctrl: table of command scenarios driven against a host/device model,
// with queue scoreboards for transmitted bytes and FIFO contents.
module tb_ps2_cmd_ctrl;
    localparam int unsigned CLK_FREQ       = 1;
    localparam int unsigned ACK_TIMEOUT_US = 40;
    localparam int unsigned MAX_RETRY      = 3;
    localparam int unsigned FIFO_AW        = 4;
    localparam int          TO_CYC         = CLK_FREQ * ACK_TIMEOUT_US;
    localparam int          DEPTH          = 1 << FIFO_AW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_arg_en = 1'b0, cmd_done, cmd_fail;
    logic [7:0] cmd_byte = 8'h00, cmd_arg = 8'h00;
    logic       rx_enable = 1'b1, fifo_rd = 1'b0, fifo_empty, fifo_ovf, ovf_clr = 1'b0;
    logic [7:0] fifo_dout, rx_err_cnt, h_tx_data;
    logic       h_tx_en, h_rx_en;
    logic       h_tx_busy = 1'b0, h_tx_ack = 1'b0, h_tx_err = 1'b0;
    logic       h_rx_ack = 1'b0, h_rx_err = 1'b0;
    logic [7:0] h_rx_data = 8'h00;

    always #5 clk = ~clk;

    ps2_cmd_ctrl #(
        .CLK_FREQ      (CLK_FREQ),
        .ACK_TIMEOUT_US(ACK_TIMEOUT_US),
        .MAX_RETRY     (MAX_RETRY),
        .FIFO_AW       (FIFO_AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_byte  (cmd_byte),
        .cmd_arg_en(cmd_arg_en),
        .cmd_arg   (cmd_arg),
        .cmd_done  (cmd_done),
        .cmd_fail  (cmd_fail),
        .rx_enable (rx_enable),
        .fifo_rd   (fifo_rd),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_ovf  (fifo_ovf),
        .ovf_clr   (ovf_clr),
        .rx_err_cnt(rx_err_cnt),
        .h_tx_en   (h_tx_en),
        .h_tx_data (h_tx_data),
        .h_rx_en   (h_rx_en),
        .h_tx_busy (h_tx_busy),
        .h_tx_ack  (h_tx_ack),
        .h_tx_err  (h_tx_err),
        .h_rx_ack  (h_rx_ack),
        .h_rx_err  (h_rx_err),
        .h_rx_data (h_rx_data)
    );

    typedef struct {
        logic [7:0] cmd;
        logic       arg_en;
        logic [7:0] arg;
        int         nfe;      // 0xFE replies to the first byte before 0xFA
        bit         silent;   // device never replies
        logic [7:0] mid;      // nonzero: stray byte during the first reply wait
        logic [7:0] post;     // nonzero: byte sent once the command is over
        bit         exp_done;
    } vec_t;

    int         n_chk = 0, n_pass = 0;
    int         done_cnt = 0, fail_cnt = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] tx_q[$];

    always @(negedge clk) begin
        if (cmd_done === 1'b1) done_cnt++;
        if (cmd_fail === 1'b1) fail_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit queued);
        h_rx_data = b;
        h_rx_ack  = 1'b1;
        if (queued) fifo_q.push_back(b);
        @(negedge clk);
        h_rx_ack  = 1'b0;
    endtask

    task automatic serve_tx(output int gap);
        logic [7:0] exp;
        gap = 0;
        while (h_tx_en !== 1'b1 && gap < TO_CYC + 10) begin
            @(negedge clk);
            gap++;
        end
        exp = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
        chk("tx_en", h_tx_en, 1);
        chk("tx_data", h_tx_data, exp);
        h_tx_busy = 1'b1;
        @(negedge clk);
        h_tx_busy = 1'b0;
        chk("tx_en_drop", h_tx_en, 0);
        h_tx_ack = 1'b1;
        @(negedge clk);
        h_tx_ack = 1'b0;
    endtask

    task automatic issue_cmd(input logic [7:0] c, input logic ae, input logic [7:0] a);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_byte   = c;
        cmd_arg_en = ae;
        cmd_arg    = a;
        @(negedge clk);
        cmd_valid  = 1'b0;
        chk("cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic drain_fifo();
        while (fifo_q.size() > 0) begin
            chk("fifo_nonempty", fifo_empty, 0);
            chk("fifo_dout", fifo_dout, fifo_q.pop_front());
            fifo_rd = 1'b1;
            @(negedge clk);
            fifo_rd = 1'b0;
        end
        chk("fifo_empty", fifo_empty, 1);
        chk("fifo_dout_empty", fifo_dout, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int gap, n, attempts0, fe_sent, d0, f0;
        bit will_fail, byte0, prev_fe, first;
        will_fail = v.silent || (v.nfe > int'(MAX_RETRY));
        attempts0 = will_fail ? int'(MAX_RETRY) + 1 : v.nfe + 1;
        for (int i = 0; i < attempts0; i++) tx_q.push_back(v.cmd);
        if (!will_fail && v.arg_en) tx_q.push_back(v.arg);
        d0 = done_cnt;
        f0 = fail_cnt;
        issue_cmd(v.cmd, v.arg_en, v.arg);
        fe_sent = 0;
        byte0   = 1'b1;
        prev_fe = 1'b0;
        first   = 1'b1;
        while (tx_q.size() > 0) begin
            serve_tx(gap);
            // silent retry: full timeout window in WAIT_ACK plus one RETRY cycle
            chk("send_gap", gap, first ? 0 : (v.silent ? TO_CYC + 1 : (prev_fe ? 1 : 0)));
            if (first && v.mid != 8'h00) send_rx(v.mid, 1'b1);
            first   = 1'b0;
            prev_fe = 1'b0;
            if (!v.silent) begin
                if (byte0 && fe_sent < v.nfe) begin
                    send_rx(8'hFE, 1'b0);
                    fe_sent++;
                    prev_fe = 1'b1;
                end else begin
                    send_rx(8'hFA, 1'b0);
                    byte0 = 1'b0;
                end
            end
        end
        n = 0;
        while (cmd_done !== 1'b1 && cmd_fail !== 1'b1 && n < TO_CYC + 10) begin
            @(negedge clk);
            n++;
        end
        chk("end_latency", n, v.silent ? TO_CYC + 1 : (will_fail ? 1 : 0));
        chk("cmd_done", cmd_done, v.exp_done);
        chk("cmd_fail", cmd_fail, !v.exp_done);
        chk("cmd_ready_end", cmd_ready, 1);
        if (v.post != 8'h00) send_rx(v.post, 1'b1);
        repeat (2) @(negedge clk);
        chk("done_pulses", done_cnt - d0, v.exp_done ? 1 : 0);
        chk("fail_pulses", fail_cnt - f0, v.exp_done ? 0 : 1);
        drain_fifo();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_chk);
        $fatal(1, "time limit");
    end

    initial begin
        vec_t       vecs[6];
        logic [7:0] b;
        int         gap, d0, f0;
        vecs[0] = '{8'hFF, 1'b0, 8'h00, 0, 1'b0, 8'h00, 8'hAA, 1'b1};
        vecs[1] = '{8'hED, 1'b1, 8'h07, 0, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[2] = '{8'hF4, 1'b0, 8'h00, 4, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{8'hF4, 1'b0, 8'h00, 0, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'hF3, 1'b1, 8'h20, 2, 1'b0, 8'h1C, 8'h00, 1'b1};
        vecs[5] = '{8'hF2, 1'b0, 8'h00, 3, 1'b0, 8'h00, 8'h00, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_cmd_done", cmd_done, 0);
        chk("rst_cmd_fail", cmd_fail, 0);
        chk("rst_tx_en", h_tx_en, 0);
        chk("rst_tx_data", h_tx_data, 0);
        chk("rst_fifo_empty", fifo_empty, 1);
        chk("rst_fifo_dout", fifo_dout, 0);
        chk("rst_fifo_ovf", fifo_ovf, 0);
        chk("rst_rx_err_cnt", rx_err_cnt, 0);
        chk("rx_en_on", h_rx_en, 1);
        rx_enable = 1'b0;
        #1;
        chk("rx_en_off", h_rx_en, 0);
        rx_enable = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // fill FIFO, then push+pop while full, then overflow and clear
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'(i + 16);
            send_rx(b, 1'b1);
        end
        chk("full_no_ovf", fifo_ovf, 0);
        chk("full_head", fifo_dout, fifo_q.pop_front());
        fifo_rd = 1'b1;
        send_rx(8'h55, 1'b1);
        fifo_rd = 1'b0;
        chk("pushpop_no_ovf", fifo_ovf, 0);
        send_rx(8'h66, 1'b0);
        chk("ovf_set", fifo_ovf, 1);
        ovf_clr = 1'b1;
        send_rx(8'h77, 1'b0);
        ovf_clr = 1'b0;
        chk("ovf_set_wins", fifo_ovf, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", fifo_ovf, 0);
        drain_fifo();

        // rx error counter and saturation
        for (int i = 0; i < 3; i++) begin
            h_rx_err = 1'b1;
            @(negedge clk);
            h_rx_err = 1'b0;
            @(negedge clk);
        end
        chk("rx_err_cnt3", rx_err_cnt, 3);
        for (int i = 0; i < 260; i++) begin
            h_rx_err = 1'b1;
            @(negedge clk);
            h_rx_err = 1'b0;
            @(negedge clk);
        end
        chk("rx_err_sat", rx_err_cnt, 255);
        chk("rx_err_idle", cmd_ready, 1);

        // reset while waiting for the device reply
        tx_q.push_back(8'hF4);
        issue_cmd(8'hF4, 1'b0, 8'h00);
        serve_tx(gap);
        send_rx(8'h1C, 1'b0);
        chk("pre_rst_fifo", fifo_empty, 0);
        chk("pre_rst_busy", cmd_ready, 0);
        d0 = done_cnt;
        f0 = fail_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ready", cmd_ready, 1);
        chk("rst_mid_fifo", fifo_empty, 1);
        chk("rst_mid_tx_en", h_tx_en, 0);
        chk("rst_mid_err_cnt", rx_err_cnt, 0);
        repeat (TO_CYC + 5) @(negedge clk);
        chk("rst_mid_no_done", done_cnt - d0, 0);
        chk("rst_mid_no_fail", fail_cnt - f0, 0);
        chk("rst_mid_idle", cmd_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
